// File: rtl/lvds_pkg.sv
// Shared state encoding, default parameter values and a small helper for the
// LVDS bitslip alignment controller.
package lvds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  localparam logic [9:0] DEF_TRAIN_PATTERN = 10'h3F0;
  localparam int DEF_MATCH_COUNT   = 16;
  localparam int DEF_SLIP_PULSE    = 2;
  localparam int DEF_SLIP_WAIT     = 4;
  localparam int DEF_MAX_SLIPS     = 10;
  localparam int FAIL_RETRY_CYCLES = 64;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/lvds_pattern_match.sv
// Training-word comparator with a saturating consecutive-match counter;
// done flags the cycle on which the final required match is seen.
import lvds_pkg::*;

module lvds_pattern_match #(
  parameter logic [9:0] PATTERN     = DEF_TRAIN_PATTERN,
  parameter int         MATCH_COUNT = DEF_MATCH_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [9:0] rx_data,
  output logic       match,
  output logic       done
);

  localparam int CW = $clog2(MATCH_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MATCH_COUNT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MATCH_COUNT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while enabled; any gap or mismatch restarts it.
  always_comb begin
    match = (rx_data == PATTERN);
    cnt_d = '0;
    if (en && match) begin
      cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
    end
    done = en && match && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lvds_bitslip_ctrl.sv
// Bitslip word-alignment FSM for an LVDS deserializer. Define
// LVDS_BITSLIP_AUTORETRY_EN to make FAIL retry automatically after 64 cycles.
import lvds_pkg::*;

module lvds_bitslip_ctrl #(
  parameter logic [9:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int         MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int         SLIP_PULSE    = DEF_SLIP_PULSE,
  parameter int         SLIP_WAIT     = DEF_SLIP_WAIT,
  parameter int         MAX_SLIPS     = DEF_MAX_SLIPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_locked,
  input  logic [9:0] rx_data,
  input  logic       realign_req,
  output logic       rx_data_align,
  output logic       align_done,
  output logic       align_fail,
  output logic [3:0] slip_cnt
);

  localparam int PW_MAX  = (SLIP_PULSE > SLIP_WAIT) ? SLIP_PULSE : SLIP_WAIT;
  localparam int TMR_MAX = (PW_MAX > FAIL_RETRY_CYCLES) ? PW_MAX : FAIL_RETRY_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(SLIP_PULSE - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(SLIP_WAIT - 1);
  localparam logic [3:0]    SLIP_LIMIT = 4'(MAX_SLIPS);
`ifdef LVDS_BITSLIP_AUTORETRY_EN
  localparam logic [TW-1:0] RETRY_LAST = TW'(FAIL_RETRY_CYCLES - 1);
`endif

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    slip_cnt_q, slip_cnt_d;
  logic          rx_data_align_q, rx_data_align_d;
  logic          align_done_q, align_done_d;
  logic          align_fail_q, align_fail_d;
  logic          pm_match, pm_done;

  lvds_pattern_match #(
    .PATTERN    (TRAIN_PATTERN),
    .MATCH_COUNT(MATCH_COUNT)
  ) u_match (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == ST_CHECK),
    .rx_data(rx_data),
    .match  (pm_match),
    .done   (pm_done)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = '0;
    slip_cnt_d = slip_cnt_q;

    case (state_q)
      ST_IDLE:   if (rx_locked) state_d = ST_CHECK;
      ST_CHECK: begin
        if (pm_done) begin
          state_d = ST_LOCKED;
        end else if (!pm_match) begin
          state_d = (slip_cnt_q < SLIP_LIMIT) ? ST_SLIP : ST_FAIL;
        end
      end
      ST_SLIP: begin
        if (tmr_q == PULSE_LAST) state_d = ST_WAIT;
        else                     tmr_d   = tmr_q + TW'(1);
      end
      ST_WAIT: begin
        if (tmr_q == WAIT_LAST) state_d = ST_CHECK;
        else                    tmr_d   = tmr_q + TW'(1);
      end
      ST_LOCKED: state_d = ST_LOCKED;
      ST_FAIL: begin
`ifdef LVDS_BITSLIP_AUTORETRY_EN
        if (tmr_q == RETRY_LAST) state_d = ST_IDLE;
        else                     tmr_d   = tmr_q + TW'(1);
`else
        state_d = ST_FAIL;
`endif
      end
      default:   state_d = ST_IDLE;
    endcase

    // A running slip pulse is never cut short by a realign request.
    if (realign_req && (state_q inside {ST_CHECK, ST_WAIT, ST_LOCKED, ST_FAIL})) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end
    if (!rx_locked) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end

    if (state_d == ST_SLIP && state_q != ST_SLIP) slip_cnt_d = sat_inc4(slip_cnt_q);
    if (state_d == ST_IDLE)                       slip_cnt_d = '0;

    // Outputs are registered copies of the next state.
    rx_data_align_d = (state_d == ST_SLIP);
    align_done_d    = (state_d == ST_LOCKED);
    align_fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      tmr_q           <= '0;
      slip_cnt_q      <= '0;
      rx_data_align_q <= 1'b0;
      align_done_q    <= 1'b0;
      align_fail_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      slip_cnt_q      <= slip_cnt_d;
      rx_data_align_q <= rx_data_align_d;
      align_done_q    <= align_done_d;
      align_fail_q    <= align_fail_d;
    end
  end

  assign rx_data_align = rx_data_align_q;
  assign align_done    = align_done_q;
  assign align_fail    = align_fail_q;
  assign slip_cnt      = slip_cnt_q;

endmodule

// File: tb/tb_lvds_bitslip_ctrl.sv
// Directed bench for lvds_bitslip_ctrl: alignment, slip sequencing, failure,
// lock loss, realign requests and asynchronous reset.
module tb_lvds_bitslip_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_locked;
  logic [9:0] rx_data;
  logic       realign_req;
  logic       rx_data_align;
  logic       align_done;
  logic       align_fail;
  logic [3:0] slip_cnt;

  int checks   = 0;
  int failures = 0;

  lvds_bitslip_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_locked    (rx_locked),
    .rx_data      (rx_data),
    .realign_req  (realign_req),
    .rx_data_align(rx_data_align),
    .align_done   (align_done),
    .align_fail   (align_fail),
    .slip_cnt     (slip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  task automatic do_reset(input logic [9:0] d);
    rst_n = 1'b0; rx_locked = 1'b1; realign_req = 1'b0; rx_data = d;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_locked = 1'b1; realign_req = 1'b0; rx_data = 10'h3F0;
    repeat (3) tick();
    checks++; if (rx_data_align !== 1'b0) begin failures++; $display("FAIL reset_align got=%b exp=0", rx_data_align); end
    checks++; if (align_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", align_done); end
    checks++; if (align_fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%b exp=0", align_fail); end
    checks++; if (slip_cnt !== 4'd0) begin failures++; $display("FAIL reset_slip_cnt got=%0d exp=0", slip_cnt); end
  endtask

  task automatic test_correct_phase();
    int n = 0; int slips = 0; int drops = 0;
    do_reset(10'h3F0);
    while (!align_done && n < 100) begin
      tick(); n++;
      if (rx_data_align) slips++;
    end
    checks++; if (n !== 17) begin failures++; $display("FAIL lock_latency got=%0d exp=17", n); end
    checks++; if (slip_cnt !== 4'd0) begin failures++; $display("FAIL lock_slip_cnt got=%0d exp=0", slip_cnt); end
    checks++; if (slips !== 0) begin failures++; $display("FAIL lock_no_slip got=%0d exp=0", slips); end
    rx_data = 10'h155;
    repeat (20) begin
      tick();
      if (!align_done || rx_data_align || align_fail) drops++;
    end
    checks++; if (drops !== 0) begin failures++; $display("FAIL locked_ignores_data got=%0d exp=0", drops); end
  endtask

  task automatic test_three_slip();
    int n = 0; int off = 3; int pulses = 0; int hi_len = 0; int lo_len = 0;
    int bad_hi = 0; int bad_lo = 0; logic prev = 1'b0;
    do_reset(rotl(10'h3F0, 3));
    while (!align_done && n < 300) begin
      tick(); n++;
      if (rx_data_align) begin
        if (!prev) begin
          pulses++;
          if (pulses > 1 && lo_len < 4) bad_lo++;
          hi_len = 0;
          if (off > 0) off--;
          rx_data = rotl(10'h3F0, off);
        end
        hi_len++;
      end else begin
        if (prev) begin
          if (hi_len != 2) bad_hi++;
          lo_len = 0;
        end
        lo_len++;
      end
      prev = rx_data_align;
    end
    checks++; if (align_done !== 1'b1) begin failures++; $display("FAIL slip3_done got=%b exp=1", align_done); end
    checks++; if (pulses !== 3) begin failures++; $display("FAIL slip3_pulses got=%0d exp=3", pulses); end
    checks++; if (bad_hi !== 0) begin failures++; $display("FAIL slip3_pulse_width bad=%0d exp=0", bad_hi); end
    checks++; if (bad_lo !== 0) begin failures++; $display("FAIL slip3_settle bad=%0d exp=0", bad_lo); end
    checks++; if (slip_cnt !== 4'd3) begin failures++; $display("FAIL slip3_slip_cnt got=%0d exp=3", slip_cnt); end
  endtask

  task automatic test_never_match();
    int n = 0; int pulses = 0; logic prev = 1'b0;
    do_reset(10'h155);
    while (!align_fail && n < 400) begin
      tick(); n++;
      if (rx_data_align && !prev) pulses++;
      prev = rx_data_align;
    end
    checks++; if (align_fail !== 1'b1) begin failures++; $display("FAIL nomatch_fail got=%b exp=1", align_fail); end
    checks++; if (pulses !== 10) begin failures++; $display("FAIL nomatch_pulses got=%0d exp=10", pulses); end
    checks++; if (slip_cnt !== 4'd10) begin failures++; $display("FAIL nomatch_slip_cnt got=%0d exp=10", slip_cnt); end
    checks++; if (align_done !== 1'b0) begin failures++; $display("FAIL nomatch_done got=%b exp=0", align_done); end
`ifdef LVDS_BITSLIP_AUTORETRY_EN
    begin
      int hold = 0; int m = 0;
      while (align_fail && hold < 200) begin tick(); hold++; end
      checks++; if (hold !== 64) begin failures++; $display("FAIL retry_hold got=%0d exp=64", hold); end
      checks++; if (slip_cnt !== 4'd0) begin failures++; $display("FAIL retry_slip_cnt got=%0d exp=0", slip_cnt); end
      while (!rx_data_align && m < 20) begin tick(); m++; end
      checks++; if (m !== 2) begin failures++; $display("FAIL retry_restart got=%0d exp=2", m); end
    end
`else
    begin
      int bad = 0;
      repeat (1000) begin
        tick();
        if (!align_fail || rx_data_align || align_done || slip_cnt != 4'd10) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL fail_sticky bad=%0d exp=0", bad); end
    end
`endif
  endtask

  task automatic test_lock_loss();
    int n = 0;
    do_reset(10'h3F0);
    while (!align_done && n < 100) begin tick(); n++; end
    rx_locked = 1'b0;
    tick();
    checks++; if (align_done !== 1'b0) begin failures++; $display("FAIL lockloss_done got=%b exp=0", align_done); end
    checks++; if (rx_data_align !== 1'b0) begin failures++; $display("FAIL lockloss_align got=%b exp=0", rx_data_align); end
    rx_locked = 1'b1;
    n = 0;
    while (!align_done && n < 100) begin tick(); n++; end
    checks++; if (n !== 17) begin failures++; $display("FAIL relock_latency got=%0d exp=17", n); end
  endtask

  task automatic test_realign_slip_wait();
    int n = 0;
    do_reset(10'h155);
    while (!rx_data_align && n < 20) begin tick(); n++; end
    checks++; if (n !== 2) begin failures++; $display("FAIL first_slip_time got=%0d exp=2", n); end
    tick();
    checks++; if (rx_data_align !== 1'b1) begin failures++; $display("FAIL slip_second_cycle got=%b exp=1", rx_data_align); end
    realign_req = 1'b1;
    tick();
    realign_req = 1'b0;
    checks++; if (rx_data_align !== 1'b0) begin failures++; $display("FAIL slip_end got=%b exp=0", rx_data_align); end
    checks++; if (slip_cnt !== 4'd1) begin failures++; $display("FAIL slip_realign_ignored got=%0d exp=1", slip_cnt); end
    realign_req = 1'b1;
    tick();
    realign_req = 1'b0;
    checks++; if (slip_cnt !== 4'd0) begin failures++; $display("FAIL wait_realign_slip_cnt got=%0d exp=0", slip_cnt); end
    tick(); tick();
    checks++; if (rx_data_align !== 1'b1 || slip_cnt !== 4'd1) begin
      failures++; $display("FAIL realign_restart got=%b/%0d exp=1/1", rx_data_align, slip_cnt);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    do_reset(10'h155);
    while (!rx_data_align && n < 20) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data_align !== 1'b0) begin failures++; $display("FAIL midpulse_align got=%b exp=0", rx_data_align); end
    checks++; if (slip_cnt !== 4'd0 || align_done !== 1'b0 || align_fail !== 1'b0) begin
      failures++; $display("FAIL midpulse_outputs got=%0d/%b/%b exp=0/0/0", slip_cnt, align_done, align_fail);
    end
    tick();
    checks++; if (rx_data_align !== 1'b0) begin failures++; $display("FAIL midpulse_hold got=%b exp=0", rx_data_align); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rx_locked = 1'b0; realign_req = 1'b0; rx_data = '0;
    test_reset();
    test_correct_phase();
    test_three_slip();
    test_never_match();
    test_lock_loss();
    test_realign_slip_wait();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
